// File: rtl/wb_sdram_bridge_pkg.sv
// Shared definitions for the Wishbone-to-SDRAM bridge: FSM state encoding,
// write-half selectors and the Wishbone byte-select to mask conversion.
package wb_sdram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_GET   = 3'd1,
        ST_WR_DATA  = 3'd2,
        ST_WR_DRAIN = 3'd3,
        ST_RD_START = 3'd4,
        ST_RD_GET   = 3'd5,
        ST_RD_DATA  = 3'd6,
        ST_RD_END   = 3'd7
    } bridge_state_e;

    localparam logic [3:0] WB_MASK_INV = 4'hF;
    localparam logic [1:0] WR_HALF0    = 2'b01;
    localparam logic [1:0] WR_HALF1    = 2'b10;
    localparam logic [1:0] WR_BOTH     = 2'b11;
    localparam logic [1:0] WR_NONE     = 2'b00;

    // A set byte-select means "write this byte"; the core wants 1 = masked.
    function automatic logic [3:0] sel_to_mask(input logic [3:0] sel);
        return sel ^ WB_MASK_INV;
    endfunction

endpackage

// File: rtl/wb_sdram_rd_drain.sv
// Read-side helper of the bridge: owns the read-half activate, the per-half
// word counter and the registered read data / pop strobe.
module wb_sdram_rd_drain
    import wb_sdram_bridge_pkg::*;
#(
    parameter int FIFO_SIZE_W = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  bridge_state_e          state_q,
    input  logic                   i_cyc,
    input  logic                   i_stb,
    input  logic                   ack_q,
    input  logic                   sdram_ready,
    input  logic                   of_read_ready,
    input  logic [FIFO_SIZE_W-1:0] of_read_count,
    input  logic [31:0]            of_read_data,
    output logic                   of_read_activate,
    output logic                   of_read_strobe,
    output logic [31:0]            rd_data,
    output logic                   rd_grant,
    output logic                   rd_beat,
    output logic                   rd_empty
);

    localparam logic [FIFO_SIZE_W-1:0] CNT_ZERO = {FIFO_SIZE_W{1'b0}};
    localparam logic [FIFO_SIZE_W-1:0] CNT_ONE  = {{(FIFO_SIZE_W-1){1'b0}}, 1'b1};

    logic                   act_q,    act_d;
    logic                   strobe_q, strobe_d;
    logic [FIFO_SIZE_W-1:0] cnt_q,    cnt_d;
    logic [31:0]            data_q,   data_d;

    assign rd_grant = (state_q == ST_RD_START) && of_read_ready && i_cyc;
    assign rd_beat  = (state_q == ST_RD_DATA) && i_cyc && i_stb && !ack_q
                      && act_q && (cnt_q != CNT_ZERO);
    // An exhausted half is released one clock after its last pop.
    assign rd_empty = (state_q == ST_RD_DATA) && (cnt_q == CNT_ZERO);

    // Next-state logic for activate, counter, read data and pop strobe.
    always_comb begin
        act_d    = act_q;
        strobe_d = 1'b0;
        cnt_d    = cnt_q;
        data_d   = data_q;
        if (!sdram_ready || !i_cyc) begin
            act_d = 1'b0;
        end else begin
            case (state_q)
                ST_RD_START: begin
                    if (rd_grant) begin
                        act_d = 1'b1;
                    end else begin
                        act_d = act_q;
                    end
                end
                ST_RD_GET: begin
                    cnt_d = of_read_count;
                end
                ST_RD_DATA: begin
                    if (rd_empty) begin
                        act_d = 1'b0;
                    end else if (rd_beat) begin
                        strobe_d = 1'b1;
                        data_d   = of_read_data;
                        cnt_d    = cnt_q - CNT_ONE;
                    end else begin
                        strobe_d = 1'b0;
                    end
                end
                default: begin
                    act_d = 1'b0;
                end
            endcase
        end
    end

    // Read-side registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q    <= 1'b0;
            strobe_q <= 1'b0;
            cnt_q    <= CNT_ZERO;
            data_q   <= 32'h0000_0000;
        end else begin
            act_q    <= act_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
        end
    end

    assign of_read_activate = act_q;
    assign of_read_strobe   = strobe_q;
    assign rd_data          = data_q;

endmodule

// File: rtl/wb_sdram_bridge.sv
// Wishbone slave front end of the SDRAM controller: one bus cycle becomes one
// SDRAM transaction, either a ping-pong write-FIFO burst or a read-FIFO drain.
module wb_sdram_bridge
    import wb_sdram_bridge_pkg::*;
#(
    parameter int ADDR_BITS   = 22,
    parameter int FIFO_SIZE_W = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wbs_cyc,
    input  logic                   i_wbs_stb,
    input  logic                   i_wbs_we,
    input  logic [3:0]             i_wbs_sel,
    input  logic [31:0]            i_wbs_adr,
    input  logic [31:0]            i_wbs_dat,
    output logic [31:0]            o_wbs_dat,
    output logic                   o_wbs_ack,
    output logic                   o_wbs_int,
    output logic                   if_write_strobe,
    output logic [31:0]            if_write_data,
    output logic [3:0]             if_write_mask,
    input  logic [1:0]             if_write_ready,
    output logic [1:0]             if_write_activate,
    input  logic [FIFO_SIZE_W-1:0] if_write_fifo_size,
    input  logic                   if_starved,
    output logic                   of_read_strobe,
    input  logic                   of_read_ready,
    output logic                   of_read_activate,
    input  logic [FIFO_SIZE_W-1:0] of_read_count,
    input  logic [31:0]            of_read_data,
    output logic                   sdram_write_enable,
    output logic                   sdram_read_enable,
    output logic [ADDR_BITS-1:0]   app_address,
    input  logic                   sdram_ready
);

    localparam logic [FIFO_SIZE_W-1:0] CNT_ZERO = {FIFO_SIZE_W{1'b0}};
    localparam logic [FIFO_SIZE_W-1:0] CNT_ONE  = {{(FIFO_SIZE_W-1){1'b0}}, 1'b1};

    bridge_state_e          state_q,     state_d;
    logic                   ack_q,       ack_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic [31:0]            wr_data_q,   wr_data_d;
    logic [3:0]             wr_mask_q,   wr_mask_d;
    logic [1:0]             wr_act_q,    wr_act_d;
    logic                   wr_en_q,     wr_en_d;
    logic                   rd_en_q,     rd_en_d;
    logic [ADDR_BITS-1:0]   addr_q,      addr_d;
    logic [FIFO_SIZE_W-1:0] wr_cnt_q,    wr_cnt_d;

    logic rd_grant_s;
    logic rd_beat_s;
    logic rd_empty_s;
    logic unused_adr_s;

    assign unused_adr_s = ^i_wbs_adr[31:ADDR_BITS];

    wb_sdram_rd_drain #(
        .FIFO_SIZE_W (FIFO_SIZE_W)
    ) u_rd_drain (
        .clk              (clk),
        .rst              (rst),
        .state_q          (state_q),
        .i_cyc            (i_wbs_cyc),
        .i_stb            (i_wbs_stb),
        .ack_q            (ack_q),
        .sdram_ready      (sdram_ready),
        .of_read_ready    (of_read_ready),
        .of_read_count    (of_read_count),
        .of_read_data     (of_read_data),
        .of_read_activate (of_read_activate),
        .of_read_strobe   (of_read_strobe),
        .rd_data          (o_wbs_dat),
        .rd_grant         (rd_grant_s),
        .rd_beat          (rd_beat_s),
        .rd_empty         (rd_empty_s)
    );

    // Transaction FSM next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        wr_strobe_d = 1'b0;
        wr_data_d   = wr_data_q;
        wr_mask_d   = wr_mask_q;
        wr_act_d    = wr_act_q;
        wr_en_d     = wr_en_q;
        rd_en_d     = rd_en_q;
        addr_d      = addr_q;
        wr_cnt_d    = wr_cnt_q;
        // Losing the core mid-transaction abandons everything at once.
        if ((state_q != ST_IDLE) && !sdram_ready) begin
            state_d  = ST_IDLE;
            wr_act_d = WR_NONE;
            wr_en_d  = 1'b0;
            rd_en_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_wbs_cyc && i_wbs_stb && sdram_ready && !ack_q) begin
                        addr_d = i_wbs_adr[ADDR_BITS-1:0];
                        if (i_wbs_we) begin
                            state_d = ST_WR_GET;
                            wr_en_d = 1'b1;
                        end else begin
                            state_d = ST_RD_START;
                            rd_en_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WR_GET: begin
                    if (!i_wbs_cyc) begin
                        state_d = ST_WR_DRAIN;
                    end else if ((if_write_ready != WR_NONE) && (wr_act_q == WR_NONE)) begin
                        wr_act_d = if_write_ready[0] ? WR_HALF0 : WR_HALF1;
                        wr_cnt_d = CNT_ZERO;
                        state_d  = ST_WR_DATA;
                    end else begin
                        state_d = ST_WR_GET;
                    end
                end
                ST_WR_DATA: begin
                    // Release the half one clock after its final push.
                    if (wr_cnt_q >= if_write_fifo_size) begin
                        wr_act_d = WR_NONE;
                        state_d  = i_wbs_cyc ? ST_WR_GET : ST_WR_DRAIN;
                    end else if (!i_wbs_cyc) begin
                        wr_act_d = WR_NONE;
                        state_d  = ST_WR_DRAIN;
                    end else if (i_wbs_stb && !ack_q) begin
                        wr_strobe_d = 1'b1;
                        wr_data_d   = i_wbs_dat;
                        wr_mask_d   = sel_to_mask(i_wbs_sel);
                        ack_d       = 1'b1;
                        wr_cnt_d    = wr_cnt_q + CNT_ONE;
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end
                ST_WR_DRAIN: begin
                    if ((if_write_ready == WR_BOTH) && if_starved) begin
                        wr_en_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WR_DRAIN;
                    end
                end
                ST_RD_START: begin
                    if (!i_wbs_cyc) begin
                        state_d = ST_RD_END;
                        rd_en_d = 1'b0;
                    end else if (rd_grant_s) begin
                        state_d = ST_RD_GET;
                    end else begin
                        state_d = ST_RD_START;
                    end
                end
                ST_RD_GET: begin
                    if (!i_wbs_cyc) begin
                        state_d = ST_RD_END;
                        rd_en_d = 1'b0;
                    end else begin
                        state_d = ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (!i_wbs_cyc) begin
                        state_d = ST_RD_END;
                        rd_en_d = 1'b0;
                    end else if (rd_empty_s) begin
                        state_d = ST_RD_START;
                    end else if (rd_beat_s) begin
                        ack_d = 1'b1;
                    end else begin
                        state_d = ST_RD_DATA;
                    end
                end
                ST_RD_END: begin
                    state_d = ST_IDLE;
                    rd_en_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    wr_act_d = WR_NONE;
                    wr_en_d  = 1'b0;
                    rd_en_d  = 1'b0;
                end
            endcase
        end
    end

    // Transaction FSM state and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_data_q   <= 32'h0000_0000;
            wr_mask_q   <= 4'h0;
            wr_act_q    <= WR_NONE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= {ADDR_BITS{1'b0}};
            wr_cnt_q    <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            wr_strobe_q <= wr_strobe_d;
            wr_data_q   <= wr_data_d;
            wr_mask_q   <= wr_mask_d;
            wr_act_q    <= wr_act_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign o_wbs_ack          = ack_q;
    assign o_wbs_int          = 1'b0;
    assign if_write_strobe    = wr_strobe_q;
    assign if_write_data      = wr_data_q;
    assign if_write_mask      = wr_mask_q;
    assign if_write_activate  = wr_act_q;
    assign sdram_write_enable = wr_en_q;
    assign sdram_read_enable  = rd_en_q;
    assign app_address        = addr_q;

endmodule
